// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS-subset control path: opcodes, functs, ALU codes,
// datapath mux selects and the multi-cycle sequencer state enum.
// Imported by the sequencer, the funct decoder and any single-cycle control unit.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;

  // ALU B-input mux
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Sequencer states; FETCH is zero so a gated-off state_dbg reads FETCH
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    ILLEGAL   = 4'd11
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct to ALU operation decoder, flags functs outside the supported set.
// Latency: purely combinational.
// Backpressure: none; output follows funct directly.
module alu_funct_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  // Map each supported funct to its ALU code; anything else is illegal
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_NOR:  alu_control = ALU_NOR;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset sequencer driving a shared-memory, single-ALU datapath.
// Latency: CPI LW 5, SW/R/ADDI 4, BEQ 3, plus one cycle per mem_ready=0 wait.
// Backpressure: FETCH/MEM_RD/MEM_WR hold on mem_ready=0; watchdog aborts to FETCH.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       r_alu;
  logic             r_legal;
  logic             wait_st;
  logic             tmo_hit;

  alu_funct_decode u_funct_dec (
    .funct       (funct),
    .alu_control (r_alu),
    .legal       (r_legal)
  );

  // Memory-handshake states; a same-cycle mem_ready always beats the watchdog
  assign wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign tmo_hit = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (tmo_cnt == TMO_LIM);

  assign state_dbg = rst_n ? state : FETCH;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Watchdog: cleared on any state change or abort, counts stalled cycles, saturates
  always_ff @(posedge clk) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if ((state_nxt != state) || tmo_hit)
      tmo_cnt <= '0;
    else if (wait_st && !mem_ready && (tmo_cnt != '1))
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Next state and datapath controls; everything defaults low, reset gates all off
  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_control   = ALU_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end else if (tmo_hit) begin
          bus_error = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_RTYPE:     state_nxt = r_legal ? R_EXEC : ILLEGAL;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDI_EXEC;
          default:      state_nxt = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_nxt = MEM_WB;
        end else if (tmo_hit) begin
          bus_error = 1'b1;
          state_nxt = FETCH;
        end
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end else if (tmo_hit) begin
          bus_error = 1'b1;
          state_nxt = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        state_nxt   = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_control   = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_nxt     = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        state_nxt  = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_control   = 3'b000;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule
